mdio_poll_arbiter: RTL

- Shares one MDIO transaction engine between two requesters: APB-driven software register accesses and an autonomous PHY link-status poller.
- Sits in the APB1 peripheral segment, between the APB register block and the MDIO shift engine. The shift engine drives eth_mdio/eth_mdc.
- Publishes the latest BMSR (PHY register 1) contents and a link-up flag for the Ethernet MAC glue and the LEDs.

---
 rtl/mdio_pkg.sv | 28 ++
 rtl/mdio_poll_arbiter_if.sv | 42 ++++
 rtl/mdio_poll_timer.sv | 40 ++++
 rtl/mdio_poll_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared MDIO op/owner/state types and BMSR constants
package mdio_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mdio_op_t;

  typedef enum logic {
    OWN_SW   = 1'b0,
    OWN_POLL = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } fsm_state_t;

  localparam logic [4:0] REG_BMSR      = 5'd1;
  localparam int         BMSR_LINK_BIT = 2;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mdio_poll_arbiter_if.sv
// rtl/mdio_poll_arbiter_if.sv - software, engine and status signals of the MDIO arbiter
interface mdio_poll_arbiter_if;

  logic        sw_req_valid;
  logic        sw_req_ready;
  logic        sw_req_write;
  logic [4:0]  sw_req_regaddr;
  logic [15:0] sw_req_wdata;
  logic        sw_rsp_valid;
  logic [15:0] sw_rsp_rdata;
  logic        sw_rsp_err;

  logic        mdio_cmd_valid;
  logic        mdio_cmd_ready;
  logic        mdio_cmd_write;
  logic [4:0]  mdio_cmd_phyaddr;
  logic [4:0]  mdio_cmd_regaddr;
  logic [15:0] mdio_cmd_wdata;
  logic        mdio_rsp_valid;
  logic [15:0] mdio_rsp_rdata;

  logic [15:0] phy_status;
  logic        phy_link_up;
  logic        poll_fail;

  modport slave (
    input  sw_req_valid, sw_req_write, sw_req_regaddr, sw_req_wdata,
    output sw_req_ready, sw_rsp_valid, sw_rsp_rdata, sw_rsp_err,
    input  mdio_cmd_ready, mdio_rsp_valid, mdio_rsp_rdata,
    output mdio_cmd_valid, mdio_cmd_write, mdio_cmd_phyaddr, mdio_cmd_regaddr, mdio_cmd_wdata,
    output phy_status, phy_link_up, poll_fail
  );

  modport master (
    output sw_req_valid, sw_req_write, sw_req_regaddr, sw_req_wdata,
    input  sw_req_ready, sw_rsp_valid, sw_rsp_rdata, sw_rsp_err,
    output mdio_cmd_ready, mdio_rsp_valid, mdio_rsp_rdata,
    input  mdio_cmd_valid, mdio_cmd_write, mdio_cmd_phyaddr, mdio_cmd_regaddr, mdio_cmd_wdata,
    input  phy_status, phy_link_up, poll_fail
  );

endinterface

// File: rtl/mdio_poll_timer.sv
// rtl/mdio_poll_timer.sv - reloadable down-counter with a one-cycle expiry pulse, gated by enable
module mdio_poll_timer
  import mdio_pkg::*;
#(
  parameter int INTERVAL = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = cnt_width(INTERVAL);
  localparam logic [W-1:0] RELOAD = W'(INTERVAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Holding en_i low freezes the count so a paused poller resumes mid-interval.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (en_i) begin
      if (cnt_q == '0) begin
        expire_o = 1'b1;
        cnt_d    = RELOAD;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mdio_poll_arbiter.sv
// rtl/mdio_poll_arbiter.sv - shares one MDIO engine between software accesses and a BMSR link poller
module mdio_poll_arbiter
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter logic [4:0] POLL_REG      = REG_BMSR,
  parameter int         POLL_INTERVAL = 1000000,
  parameter int         RSP_TIMEOUT   = 4096
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               poll_en,
  mdio_poll_arbiter_if.slave bus
);

  localparam int TMO_W = cnt_width(RSP_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(RSP_TIMEOUT - 1);

  fsm_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_grant_q, last_grant_d;
  mdio_op_t         op_q, op_d;
  logic [4:0]       regaddr_q, regaddr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             poll_pending_q, poll_pending_d;
  logic             sw_rsp_valid_q, sw_rsp_valid_d;
  logic [15:0]      sw_rsp_rdata_q, sw_rsp_rdata_d;
  logic             sw_rsp_err_q, sw_rsp_err_d;
  logic [15:0]      phy_status_q, phy_status_d;
  logic             poll_fail_q, poll_fail_d;

  logic             poll_expire;
  logic             grant_sw;
  logic             grant_poll;

  mdio_poll_timer #(
    .INTERVAL (POLL_INTERVAL)
  ) u_poll_timer (
    .clk      (pclk),
    .rst_n    (preset_n),
    .en_i     (poll_en),
    .expire_o (poll_expire)
  );

  // Round-robin only matters when both requesters are pending in the same IDLE cycle.
  always_comb begin
    grant_sw   = 1'b0;
    grant_poll = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.sw_req_valid && poll_pending_q) begin
        if (last_grant_q == OWN_POLL) begin
          grant_sw = 1'b1;
        end else begin
          grant_poll = 1'b1;
        end
      end else if (bus.sw_req_valid) begin
        grant_sw = 1'b1;
      end else if (poll_pending_q) begin
        grant_poll = 1'b1;
      end
    end
  end

  // An expiry in the grant cycle wins over the clear, so that poll is kept.
  assign poll_pending_d = poll_expire | (poll_pending_q & ~grant_poll);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    op_d           = op_q;
    regaddr_d      = regaddr_q;
    wdata_d        = wdata_q;
    tmo_d          = tmo_q;
    sw_rsp_valid_d = 1'b0;
    sw_rsp_rdata_d = sw_rsp_rdata_q;
    sw_rsp_err_d   = sw_rsp_err_q;
    phy_status_d   = phy_status_q;
    poll_fail_d    = poll_fail_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_sw) begin
          owner_d      = OWN_SW;
          last_grant_d = OWN_SW;
          op_d         = bus.sw_req_write ? OP_WRITE : OP_READ;
          regaddr_d    = bus.sw_req_regaddr;
          wdata_d      = bus.sw_req_wdata;
          state_d      = ST_ISSUE;
        end else if (grant_poll) begin
          owner_d      = OWN_POLL;
          last_grant_d = OWN_POLL;
          op_d         = OP_READ;
          regaddr_d    = POLL_REG;
          wdata_d      = '0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (bus.mdio_cmd_ready) begin
          tmo_d   = TMO_RELOAD;
          state_d = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (bus.mdio_rsp_valid) begin
          if (owner_q == OWN_SW) begin
            sw_rsp_valid_d = 1'b1;
            sw_rsp_rdata_d = bus.mdio_rsp_rdata;
            sw_rsp_err_d   = 1'b0;
          end else begin
            phy_status_d = bus.mdio_rsp_rdata;
            poll_fail_d  = 1'b0;
          end
          state_d = ST_IDLE;
        end else if (tmo_q == '0) begin
          // A failed poll keeps the last good status visible to the MAC and LEDs.
          if (owner_q == OWN_SW) begin
            sw_rsp_valid_d = 1'b1;
            sw_rsp_rdata_d = 16'hffff;
            sw_rsp_err_d   = 1'b1;
          end else begin
            poll_fail_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_SW;
      last_grant_q   <= OWN_POLL;
      op_q           <= OP_READ;
      regaddr_q      <= '0;
      wdata_q        <= '0;
      tmo_q          <= '0;
      poll_pending_q <= 1'b0;
      sw_rsp_valid_q <= 1'b0;
      sw_rsp_rdata_q <= '0;
      sw_rsp_err_q   <= 1'b0;
      phy_status_q   <= '0;
      poll_fail_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      op_q           <= op_d;
      regaddr_q      <= regaddr_d;
      wdata_q        <= wdata_d;
      tmo_q          <= tmo_d;
      poll_pending_q <= poll_pending_d;
      sw_rsp_valid_q <= sw_rsp_valid_d;
      sw_rsp_rdata_q <= sw_rsp_rdata_d;
      sw_rsp_err_q   <= sw_rsp_err_d;
      phy_status_q   <= phy_status_d;
      poll_fail_q    <= poll_fail_d;
    end
  end

  assign bus.sw_req_ready     = grant_sw;
  assign bus.sw_rsp_valid     = sw_rsp_valid_q;
  assign bus.sw_rsp_rdata     = sw_rsp_rdata_q;
  assign bus.sw_rsp_err       = sw_rsp_err_q;

  assign bus.mdio_cmd_valid   = (state_q == ST_ISSUE);
  assign bus.mdio_cmd_write   = (op_q == OP_WRITE);
  assign bus.mdio_cmd_phyaddr = (state_q == ST_ISSUE) ? PHY_ADDR : 5'd0;
  assign bus.mdio_cmd_regaddr = regaddr_q;
  assign bus.mdio_cmd_wdata   = wdata_q;

  assign bus.phy_status       = phy_status_q;
  assign bus.phy_link_up      = phy_status_q[BMSR_LINK_BIT];
  assign bus.poll_fail        = poll_fail_q;

endmodule
